// File: rtl/bitwise_pkg.sv
// Shared types and the per-bit operation helper for the bitwise logic unit.
// Optional statistics outputs are enabled with BITWISE_STATS_EN.
package bitwise_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_ORN  = 3'd7
    } op_e;

    localparam int DEFAULT_WIDTH = 3;

    // Single-bit form: every op is bitwise, so callers map it over a vector.
    function automatic logic apply_op(op_e op, logic a, logic b);
        logic res;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_XNOR: res = ~(a ^ b);
            OP_ANDN: res = a & ~b;
            OP_ORN:  res = a | ~b;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bitwise_reduce.sv
// Combinational reductions of a result vector: any-set, popcount, parity.
// Popcount and parity exist only when BITWISE_STATS_EN is defined.
module bitwise_reduce
    import bitwise_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] r,
    output logic             any_set,
    output logic [CW-1:0]    cnt,
    output logic             par
);

    assign any_set = |r;

`ifdef BITWISE_STATS_EN
    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CW'(r[i]);
        end
    end

    assign par = ^r;
`else
    assign cnt = '0;
    assign par = 1'b0;
`endif

endmodule

// File: rtl/bitwise.sv
// Registered bitwise logic unit: r = x OP y with any-set, equality and stats flags.
// Statistics (cnt, par) are live only when BITWISE_STATS_EN is defined.
module bitwise
    import bitwise_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    parameter op_e OP    = OP_AND,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             z,
    output logic [WIDTH-1:0] r,
    output logic             eq,
    output logic             zero_all,
    output logic [CW-1:0]    cnt,
    output logic             par
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("bitwise: WIDTH must be >= 1");
        end
        case (OP)
            OP_AND, OP_OR, OP_XOR, OP_NAND,
            OP_NOR, OP_XNOR, OP_ANDN, OP_ORN: begin : g_op_ok
            end
            default: begin : g_bad_op
                $error("bitwise: illegal OP");
            end
        endcase
    endgenerate

    logic [WIDTH-1:0] r_c;
    logic             any_c;
    logic [CW-1:0]    cnt_c;
    logic             par_c;

    always_comb begin
        r_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r_c[i] = apply_op(OP, x[i], y[i]);
        end
    end

    // Flags come from the same combinational r that is registered.
    bitwise_reduce #(
        .WIDTH (WIDTH)
    ) u_reduce (
        .r       (r_c),
        .any_set (any_c),
        .cnt     (cnt_c),
        .par     (par_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            z        <= 1'b0;
            r        <= '0;
            eq       <= 1'b0;
            zero_all <= 1'b1;
            cnt      <= '0;
            par      <= 1'b0;
        end else begin
            z        <= any_c;
            r        <= r_c;
            eq       <= (x == y);
            zero_all <= ~any_c;
            cnt      <= cnt_c;
            par      <= par_c;
        end
    end

endmodule

// File: tb/tb_bitwise.sv
// Directed and random checks of bitwise for AND/XOR/NOR at WIDTH=3 and AND at WIDTH=1.
// Expected stats depend on whether BITWISE_STATS_EN is defined.
module tb_bitwise;
    import bitwise_pkg::*;

`ifdef BITWISE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] x, y;

    logic       a_z, a_eq, a_zero, a_par;
    logic [2:0] a_r;
    logic [1:0] a_cnt;
    logic       o_z, o_eq, o_zero, o_par;
    logic [2:0] o_r;
    logic [1:0] o_cnt;
    logic       n_z, n_eq, n_zero, n_par;
    logic [2:0] n_r;
    logic [1:0] n_cnt;
    logic       w_z, w_eq, w_zero, w_par, w_r, w_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bitwise #(.WIDTH(3), .OP(OP_AND)) u_and (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .z(a_z), .r(a_r), .eq(a_eq), .zero_all(a_zero),
        .cnt(a_cnt), .par(a_par)
    );

    bitwise #(.WIDTH(3), .OP(OP_XOR)) u_xor (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .z(o_z), .r(o_r), .eq(o_eq), .zero_all(o_zero),
        .cnt(o_cnt), .par(o_par)
    );

    bitwise #(.WIDTH(3), .OP(OP_NOR)) u_nor (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .z(n_z), .r(n_r), .eq(n_eq), .zero_all(n_zero),
        .cnt(n_cnt), .par(n_par)
    );

    bitwise #(.WIDTH(1), .OP(OP_AND)) u_w1 (
        .clk(clk), .rst(rst), .x(x[0]), .y(y[0]),
        .z(w_z), .r(w_r), .eq(w_eq), .zero_all(w_zero),
        .cnt(w_cnt), .par(w_par)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pop3(logic [2:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]);
    endfunction

    // Check one WIDTH=3 unit given its expected result and equality.
    task automatic check_unit(input string tag,
                              input logic [2:0] r_got, input logic z_got,
                              input logic eq_got, input logic zero_got,
                              input logic [1:0] cnt_got, input logic par_got,
                              input logic [2:0] r_exp, input logic eq_exp);
        check({tag, ".r"}, 32'(r_got), 32'(r_exp));
        check({tag, ".z"}, 32'(z_got), 32'(r_exp != 3'd0));
        check({tag, ".eq"}, 32'(eq_got), 32'(eq_exp));
        check({tag, ".zero_all"}, 32'(zero_got), 32'(r_exp == 3'd0));
        check({tag, ".cnt"}, 32'(cnt_got), STATS ? 32'(pop3(r_exp)) : 32'd0);
        check({tag, ".par"}, 32'(par_got), STATS ? 32'(^r_exp) : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] xs, ys;
        rst = 1'b1;
        x   = 3'd0;
        y   = 3'd0;
        step();
        step();
        // x==y during reset, but eq must stay 0 because reset wins
        check("rst.z", 32'(a_z), 32'd0);
        check("rst.r", 32'(a_r), 32'd0);
        check("rst.eq", 32'(a_eq), 32'd0);
        check("rst.zero_all", 32'(a_zero), 32'd1);
        check("rst.cnt", 32'(a_cnt), 32'd0);
        check("rst.par", 32'(a_par), 32'd0);
        check("rst.nor_r", 32'(n_r), 32'd0);

        rst = 1'b0;
        x = 3'd3; y = 3'd4;
        step();
        check_unit("and_3_4", a_r, a_z, a_eq, a_zero, a_cnt, a_par, 3'd0, 1'b0);

        x = 3'd7; y = 3'd5;
        step();
        check_unit("and_7_5", a_r, a_z, a_eq, a_zero, a_cnt, a_par, 3'd5, 1'b0);
        check("and_7_5.cnt_hand", 32'(a_cnt), STATS ? 32'd2 : 32'd0);
        // Latency: new operands must not show before the next edge
        x = 3'd0; y = 3'd1;
        #2;
        check("latency.r", 32'(a_r), 32'd5);
        step();
        check_unit("and_0_1", a_r, a_z, a_eq, a_zero, a_cnt, a_par, 3'd0, 1'b0);

        x = 3'd3; y = 3'd3;
        step();
        check_unit("and_3_3", a_r, a_z, a_eq, a_zero, a_cnt, a_par, 3'd3, 1'b1);
        check("w1_1_1.r", 32'(w_r), 32'd1);
        check("w1_1_1.cnt", 32'(w_cnt), STATS ? 32'd1 : 32'd0);

        x = 3'd5; y = 3'd5;
        step();
        check_unit("xor_5_5", o_r, o_z, o_eq, o_zero, o_cnt, o_par, 3'd0, 1'b1);
        check_unit("and_5_5", a_r, a_z, a_eq, a_zero, a_cnt, a_par, 3'd5, 1'b1);

        x = 3'd7; y = 3'd7;
        step();
        check_unit("xor_7_7", o_r, o_z, o_eq, o_zero, o_cnt, o_par, 3'd0, 1'b1);
        check_unit("nor_7_7", n_r, n_z, n_eq, n_zero, n_cnt, n_par, 3'd0, 1'b1);

        x = 3'd0; y = 3'd0;
        step();
        check_unit("nor_0_0", n_r, n_z, n_eq, n_zero, n_cnt, n_par, 3'd7, 1'b1);
        check_unit("and_0_0", a_r, a_z, a_eq, a_zero, a_cnt, a_par, 3'd0, 1'b1);
        check("w1_0_0.zero_all", 32'(w_zero), 32'd1);

        x = 3'd1; y = 3'd0;
        step();
        check("w1_1_0.r", 32'(w_r), 32'd0);
        check("w1_1_0.eq", 32'(w_eq), 32'd0);
        check_unit("xor_1_0", o_r, o_z, o_eq, o_zero, o_cnt, o_par, 3'd1, 1'b0);

        // Reset mid-stream with operands held
        x = 3'd7; y = 3'd7;
        step();
        check("mid.pre_r", 32'(a_r), 32'd7);
        rst = 1'b1;
        step();
        check("mid.rst_r", 32'(a_r), 32'd0);
        check("mid.rst_z", 32'(a_z), 32'd0);
        check("mid.rst_eq", 32'(a_eq), 32'd0);
        check("mid.rst_zero_all", 32'(a_zero), 32'd1);
        check("mid.rst_w1_r", 32'(w_r), 32'd0);
        rst = 1'b0;
        step();
        check_unit("mid.post", a_r, a_z, a_eq, a_zero, a_cnt, a_par, 3'd7, 1'b1);

        for (int i = 0; i < 100; i++) begin
            xs = 3'($urandom_range(0, 7));
            ys = 3'($urandom_range(0, 7));
            x = xs;
            y = ys;
            step();
            check_unit("rnd_and", a_r, a_z, a_eq, a_zero, a_cnt, a_par,
                       xs & ys, xs == ys);
            check_unit("rnd_xor", o_r, o_z, o_eq, o_zero, o_cnt, o_par,
                       xs ^ ys, xs == ys);
            check_unit("rnd_nor", n_r, n_z, n_eq, n_zero, n_cnt, n_par,
                       ~(xs | ys), xs == ys);
            check("rnd_w1.r", 32'(w_r), 32'(xs[0] & ys[0]));
            check("rnd_w1.cnt", 32'(w_cnt), STATS ? 32'(xs[0] & ys[0]) : 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bitwise.md
Name: bitwise

Overview:
- Registered bitwise logic unit.
- Applies a compile-time-selected bitwise operation to two WIDTH-bit operands and produces:
  - a 1-bit "any result bit set" flag (z),
  - the full result vector,
  - compare flags.
- Sits in datapath glue logic wherever a flagged mask/overlap test between two small fields is needed.

Parameters:
- WIDTH, 3, operand width in bits (>=1).
- OP, bitwise_pkg::OP_AND, operation select (enum op_e): OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_ANDN (x & ~y), OP_ORN (x | ~y).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- z  output  1  registered reduction-OR of the result vector (1 = any result bit set)
- r  output  WIDTH  registered result vector, r = x OP y
- eq  output  1  registered x == y
- zero_all  output  1  registered (r == 0); always equals ~z
- cnt  output  $clog2(WIDTH+1)  registered popcount of r (see Optional Feature)
- par  output  1  registered XOR-reduction of r (see Optional Feature)

Behaviour:
- Single register stage; latency exactly 1 clk.
  - Outputs at edge N+1 reflect x/y sampled at edge N.
  - No handshake; a new operand pair is accepted every cycle.
- Reset:
  - When rst=1 at a rising edge: z=0, r=0, eq=0, zero_all=1, cnt=0, par=0.
  - rst has priority over new operands.
  - Reset mid-stream discards the in-flight result.
  - Outputs after rst=0 reflect the first operands sampled with rst low.
- Result computation per OP:
  - Bitwise over all WIDTH bits; no carries; no width growth.
  - Unused or unknown OP values are illegal: elaboration error via static assertion.
- z = |r, computed from the same combinational r that is registered (not from registered r), so z and r are coherent in the same cycle.
- eq compares raw operands, independent of OP.
- Boundaries:
  - x=0,y=0 with OP_AND -> z=0.
  - All-ones operands with OP_XOR -> r=0, z=0, eq=1.
  - WIDTH=1 must work: cnt is 1 bit wide.
- No X propagation requirement beyond standard; outputs are defined after the first reset.

Optional Feature:
- Macro BITWISE_STATS_EN.
  - Defined: cnt and par are computed from r and registered with the same latency and reset as z.
  - Undefined: cnt and par ports still exist but are tied to constant 0, and no popcount logic is synthesized.

Decomposition:
- bitwise_pkg holds:
  - typedef enum op_e (3-bit encoding, OP_AND=0 through OP_ORN=7),
  - function apply_op(op_e, a, b) for use by RTL and bench models,
  - localparam DEFAULT_WIDTH=3.
- One sub-module, bitwise_reduce: combinational; takes r and produces any-set, popcount and parity; instantiated once in bitwise.

Test Plan:
- OP_AND, WIDTH=3, after reset: x=3,y=4 -> next cycle r=0, z=0, zero_all=1, eq=0.
- OP_AND: x=7,y=5 -> r=5, z=1, eq=0; with BITWISE_STATS_EN, cnt=2, par=0.
- OP_AND: x=0,y=1 -> r=0, z=0; then x=3,y=3 -> r=3, z=1, eq=1; with BITWISE_STATS_EN, cnt=2.
- Reset mid-stream: x=7,y=7 held, rst=1 for one cycle -> outputs 0/zero_all=1 that cycle, then r=7, z=1 one cycle after rst drops.
- OP_XOR: x=5,y=5 -> r=0, z=0, eq=1; OP_NOR x=0,y=0 -> r=7, z=1.
- Without BITWISE_STATS_EN, random operands for 100 cycles -> cnt=0 and par=0 always; z, r and eq match the apply_op model at 1-cycle latency.
